// File: rtl/dcmprog_pkg.sv
// Shared types and constants for the DCM_CLKGEN run-time M/D reprogrammer.
package dcmprog_pkg;

  typedef enum logic [3:0] {
    IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, WAIT_LOCK, FINISH, ERR
  } state_e;

  // Command prefixes, bit0 goes out on PROGDATA first.
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_BAD_PARAM    = 2'd1;
  localparam logic [1:0] ERR_DONE_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LOCK_TIMEOUT = 2'd3;

  localparam logic [8:0] M_MIN = 9'd2;
  localparam logic [8:0] M_MAX = 9'd256;
  localparam logic [8:0] D_MIN = 9'd1;
  localparam logic [8:0] D_MAX = 9'd256;

  // True when M and D are inside the DCM_CLKGEN legal ranges.
  function automatic logic params_ok(input logic [8:0] m, input logic [8:0] d);
    return (m >= M_MIN) && (m <= M_MAX) && (d >= D_MIN) && (d <= D_MAX);
  endfunction

endpackage

// File: rtl/dcmprog_shifter.sv
// 10-bit parallel-load shift register feeding PROGDATA, LSB first.
// Zeros shift in behind the frame, so the serial output idles low once a
// frame has fully left; last_o flags the tenth (final) bit on the line.
module dcmprog_shifter
  import dcmprog_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [1:0] cmd_i,
  input  logic [7:0] val_i,
  output logic       ser_o,
  output logic       last_o
);

  logic [9:0] sr_q;
  logic [3:0] cnt_q;

  // Load a {value, command} frame or advance one bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= {val_i, cmd_i};
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {1'b0, sr_q[9:1]};
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign ser_o  = sr_q[0];
  assign last_o = (cnt_q == 4'd9);

endmodule

// File: rtl/dcm_clkgen_prog.sv
// Run-time M/D reprogrammer for a Spartan-6 DCM_CLKGEN.
// Accepts one (M, D) request, shifts LOAD_D / LOAD_M / GO onto PROGEN and
// PROGDATA, then waits for a PROGDONE rising edge.
// Define DCMPROG_LOCK_WAIT_EN to additionally wait for LOCKED after PROGDONE.
module dcm_clkgen_prog
  import dcmprog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [8:0] cfg_m,
  input  logic [8:0] cfg_d,
  output logic       prog_en,
  output logic       prog_data,
  input  logic       prog_done,
  input  logic       dcm_locked,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_e        state_q, state_d;
  logic [8:0]    m_q, m_d, d_q, d_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          low_seen_q, low_seen_d;
  logic [1:0]    code_q, code_d;
  logic          en_q, ready_q, busy_q, done_q, err_q;

  logic          sh_load, sh_shift, sh_ser, sh_last;
  logic [1:0]    sh_cmd;
  logic [7:0]    sh_val;
  logic [7:0]    dv_w, mv_w;
  logic          gap_last, tmo_hit;

  assign dv_w     = 8'(cfg_d - 9'd1);
  assign mv_w     = 8'(m_q - 9'd1);
  assign gap_last = (gap_q == GW'(GAP_CYC - 1));
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC - 1));

`ifndef DCMPROG_LOCK_WAIT_EN
  logic unused_lock;
  assign unused_lock = dcm_locked;
`endif

  dcmprog_shifter u_shifter (
    .clk_i   (clkin),
    .rst_ni  (rst_n),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .cmd_i   (sh_cmd),
    .val_i   (sh_val),
    .ser_o   (sh_ser),
    .last_o  (sh_last)
  );

  // Next-state, counters and shifter control.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    d_d        = d_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    low_seen_d = low_seen_q;
    code_d     = code_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_cmd     = CMD_LOAD_D;
    sh_val     = '0;
    case (state_q)
      IDLE: if (cfg_valid) begin
        m_d    = cfg_m;
        d_d    = cfg_d;
        code_d = ERR_NONE;
        if (params_ok(cfg_m, cfg_d)) begin
          state_d = LOAD_D;
          sh_load = 1'b1;
          sh_cmd  = CMD_LOAD_D;
          sh_val  = dv_w;
        end else begin
          state_d = ERR;
          code_d  = ERR_BAD_PARAM;
        end
      end
      LOAD_D: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          state_d = GAP_D;
          gap_d   = '0;
        end
      end
      GAP_D: begin
        if (gap_last) begin
          state_d = LOAD_M;
          sh_load = 1'b1;
          sh_cmd  = CMD_LOAD_M;
          sh_val  = mv_w;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      LOAD_M: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          state_d = GAP_M;
          gap_d   = '0;
        end
      end
      GAP_M: begin
        if (gap_last) state_d = GO;
        else          gap_d   = gap_q + GW'(1);
      end
      GO: begin
        state_d    = WAIT_DONE;
        tmo_d      = '0;
        low_seen_d = 1'b0;
      end
      // A rising edge needs a low sample first; a level already high on entry doesn't count.
      WAIT_DONE: begin
        if (low_seen_q && prog_done) begin
`ifdef DCMPROG_LOCK_WAIT_EN
          state_d = WAIT_LOCK;
          tmo_d   = '0;
`else
          state_d = FINISH;
`endif
        end else if (tmo_hit) begin
          state_d = ERR;
          code_d  = ERR_DONE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (!prog_done) low_seen_d = 1'b1;
        end
      end
`ifdef DCMPROG_LOCK_WAIT_EN
      WAIT_LOCK: begin
        if (dcm_locked) begin
          state_d = FINISH;
        end else if (tmo_hit) begin
          state_d = ERR;
          code_d  = ERR_LOCK_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`endif
      FINISH:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      m_q        <= '0;
      d_q        <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      low_seen_q <= 1'b0;
      code_q     <= ERR_NONE;
      en_q       <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      d_q        <= d_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      low_seen_q <= low_seen_d;
      code_q     <= code_d;
      en_q       <= (state_d == LOAD_D) || (state_d == LOAD_M) || (state_d == GO);
      ready_q    <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == FINISH);
      err_q      <= (state_d == ERR);
    end
  end

  assign cfg_ready = ready_q;
  assign prog_en   = en_q;
  assign prog_data = sh_ser;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Scoreboard bench for dcm_clkgen_prog: driver pushes a modelled expectation
// per request, a negedge monitor pops it on accept and checks the PROGEN /
// PROGDATA trace, the done/err pulse cycle, err_code and ready recovery.
module tb_dcm_clkgen_prog;

  localparam int T = 16;
  localparam int G = 2;

  logic       clkin = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0;
  logic [8:0] cfg_m = '0, cfg_d = '0;
  logic       prog_done = 1'b0, dcm_locked = 1'b0;
  logic       cfg_ready, prog_en, prog_data, busy, done, err;
  logic [1:0] err_code;

  dcm_clkgen_prog #(.TIMEOUT_CYC(T), .GAP_CYC(G)) dut (
    .clkin(clkin), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m(cfg_m), .cfg_d(cfg_d), .prog_en(prog_en), .prog_data(prog_data),
    .prog_done(prog_done), .dcm_locked(dcm_locked), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  // DCM behaviour per request, in cycles relative to the accept cycle (0).
  typedef struct { bit init; int lo_k; int hi_k; int lk_k; } resp_t;
  typedef struct { int pulse_k; bit is_err; logic [1:0] code;
                   logic [127:0] en; logic [127:0] dat; bit abort; } exp_t;

  exp_t  sb[$];
  resp_t cur = '{1'b0, 0, 1000, 1000};
  resp_t pend;
  int    acc_cyc = -1000;
  int    checks = 0, errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit pd_at(input resp_t r, input int k);
    if (k >= r.hi_k) return 1'b1;
    if (k >= r.lo_k) return 1'b0;
    return r.init;
  endfunction

  function automatic bit lk_at(input resp_t r, input int k);
    return k >= r.lk_k;
  endfunction

  // Reference: frame layout from the command format, result from the
  // PROGDONE/LOCKED schedule and the timeout window.
  function automatic exp_t model(input logic [8:0] m, input logic [8:0] d, input resp_t r);
    exp_t e;
    int dv, mv, w, fin, base_m;
    bit seen;
    e.en = '0; e.dat = '0; e.abort = 1'b0; e.is_err = 1'b0; e.code = 2'd0; e.pulse_k = 0;
    if (int'(m) < 2 || int'(m) > 256 || int'(d) < 1 || int'(d) > 256) begin
      e.pulse_k = 1; e.is_err = 1'b1; e.code = 2'd1;
      return e;
    end
    dv = int'(d) - 1;
    mv = int'(m) - 1;
    base_m = 11 + G;
    for (int i = 0; i < 10; i++) begin
      e.en[1 + i]      = 1'b1;
      e.en[base_m + i] = 1'b1;
      e.dat[1 + i]      = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'(dv >> (i - 2));
      e.dat[base_m + i] = (i < 2) ? 1'b1 : 1'(mv >> (i - 2));
    end
    e.en[21 + 2*G] = 1'b1;
    w = 22 + 2*G;
    seen = 1'b0;
    fin = -1;
    for (int k = w; k < w + T && fin < 0; k++) begin
      if (seen && pd_at(r, k)) fin = k;
      else if (!pd_at(r, k))   seen = 1'b1;
    end
    if (fin < 0) begin
      e.pulse_k = w + T; e.is_err = 1'b1; e.code = 2'd2;
    end else begin
`ifdef DCMPROG_LOCK_WAIT_EN
      e.pulse_k = fin + 1 + T; e.is_err = 1'b1; e.code = 2'd3;
      for (int k = fin + T; k >= fin + 1; k--)
        if (lk_at(r, k)) begin e.pulse_k = k + 1; e.is_err = 1'b0; e.code = 2'd0; end
`else
      e.pulse_k = fin + 1;
`endif
    end
    return e;
  endfunction

  // DCM stand-in: drives PROGDONE/LOCKED for the current relative cycle.
  always @(posedge clkin) begin
    #2;
    prog_done  = pd_at(cur, cyc - acc_cyc);
    dcm_locked = lk_at(cur, cyc - acc_cyc);
  end

  // Monitor
  bit         active = 1'b0, post = 1'b0, tr_bad = 1'b0;
  int         k = 0, tr_k = -1;
  exp_t       ce;
  logic [1:0] last_code = 2'd0;

  always @(negedge clkin) begin
    if (!rst_n) begin
      if (active) begin
        chk("aborted_by_reset_expected", int'(ce.abort), 1);
        active = 1'b0;
      end
      post = 1'b0;
    end else begin
      if (active) begin
        k++;
        if (!tr_bad && (prog_en !== ce.en[k] || prog_data !== ce.dat[k])) begin
          tr_bad = 1'b1; tr_k = k;
        end
        if (done || err || k >= ce.pulse_k || k >= 127) begin
          chk("pulse_cycle", k, ce.pulse_k);
          chk("pulse_err", int'(err), int'(ce.is_err));
          chk("pulse_done", int'(done), int'(!ce.is_err));
          chk("err_code", int'(err_code), int'(ce.code));
          chk("trace_first_bad_cycle", tr_bad ? tr_k : -1, -1);
          chk("completed_not_aborted", int'(ce.abort), 0);
          last_code = ce.code;
          active = 1'b0;
          post = 1'b1;
        end
      end else begin
        if (post) begin
          chk("ready_after_pulse", int'(cfg_ready), 1);
          chk("busy_after_pulse", int'(busy), 0);
          chk("err_code_held", int'(err_code), int'(last_code));
          post = 1'b0;
        end else begin
          chk("idle_quiet", int'({prog_en, done, err}), 0);
        end
        if (cfg_valid && cfg_ready) begin
          chk("accept_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            ce = sb.pop_front();
            active = 1'b1; k = 0; tr_bad = 1'b0; tr_k = -1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [8:0] m, input logic [8:0] d, input resp_t r,
                       input bit abort, input bit keep);
    exp_t e;
    int   n;
    bit   got;
    e = model(m, d, r);
    e.abort = abort;
    sb.push_back(e);
    pend = r;
    cfg_m = m; cfg_d = d; cfg_valid = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clkin);
      if (cfg_ready && rst_n) got = 1'b1;
      else n++;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clkin); #1;
    acc_cyc = cyc - 1;
    cur = pend;
    if (!keep) begin
      cfg_valid = 1'b0;
      cfg_m = 9'($urandom);
      cfg_d = 9'($urandom);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_prog_en"},   int'(prog_en), 0);
    chk({tag, "_prog_data"}, int'(prog_data), 0);
    chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_err"},       int'(err), 0);
    chk({tag, "_err_code"},  int'(err_code), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t rn, r;
    logic [8:0] m, d;
    int n;
    rn = '{1'b1, 27, 30, 0};

    #12;
    chk_reset_outputs("reset");
    @(posedge clkin); #1;
    rst_n = 1'b1;

    issue(9'd3,   9'd50,  rn, 1'b0, 1'b0);
    issue(9'd1,   9'd4,   rn, 1'b0, 1'b0);
    issue(9'd0,   9'd5,   rn, 1'b0, 1'b0);
    issue(9'd2,   9'd0,   rn, 1'b0, 1'b0);
    issue(9'd257, 9'd1,   rn, 1'b0, 1'b0);
    issue(9'd256, 9'd257, rn, 1'b0, 1'b0);
    issue(9'd2,   9'd1,   rn, 1'b0, 1'b0);
    issue(9'd256, 9'd256, '{1'b1, 1000, 1000, 0}, 1'b0, 1'b0); // never low
    issue(9'd100, 9'd7,   '{1'b0, 0, 1000, 0}, 1'b0, 1'b0);    // never high
    issue(9'd17,  9'd33,  '{1'b0, 0, 5, 0}, 1'b0, 1'b0);       // pulse before wait
    issue(9'd4,   9'd9,   '{1'b1, 10, 28, 0}, 1'b0, 1'b0);     // low on entry
    issue(9'd5,   9'd6,   '{1'b0, 0, 41, 0}, 1'b0, 1'b0);      // rise on last cycle
    issue(9'd6,   9'd5,   '{1'b0, 0, 42, 0}, 1'b0, 1'b0);      // one cycle late
`ifdef DCMPROG_LOCK_WAIT_EN
    issue(9'd3, 9'd50, '{1'b1, 27, 30, 1000}, 1'b0, 1'b0);     // lock stuck low
    issue(9'd3, 9'd50, '{1'b1, 27, 30, 36}, 1'b0, 1'b0);       // lock after 5
`endif

    // Reset in the middle of LOAD_M, then a clean re-issue.
    issue(9'd3, 9'd50, rn, 1'b1, 1'b0);
    while (cyc - acc_cyc < 17) begin @(posedge clkin); #1; end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midop_reset");
    repeat (2) @(posedge clkin);
    #1;
    rst_n = 1'b1;
    issue(9'd3, 9'd50, rn, 1'b0, 1'b0);

    // Valid held through busy: the second request waits for ready.
    issue(9'd5, 9'd7,  rn, 1'b0, 1'b1);
    issue(9'd9, 9'd11, rn, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        m = 9'($urandom_range(0, 300));
        d = 9'($urandom_range(0, 300));
      end else begin
        m = 9'($urandom_range(2, 256));
        d = 9'($urandom_range(1, 256));
      end
      r.init = 1'($urandom_range(0, 1));
      r.lo_k = $urandom_range(15, 45);
      r.hi_k = r.lo_k + $urandom_range(0, 10);
      r.lk_k = $urandom_range(20, 70);
      issue(m, d, r, 1'b0, 1'b0);
    end

    n = 0;
    while ((sb.size() != 0 || active || post) && n < 500) begin
      @(negedge clkin);
      n++;
    end
    chk("drain", int'(n < 500), 1);
    repeat (3) @(negedge clkin);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
